coin_acceptor: RTL and testbench
================================

// Module: coin_acceptor
// PURPOSE
//   Front end of the vending machine. Turns two raw coin-sensor lines ($5, $10) into
//   the 2-bit coin code the vending FSM samples every clock: 00 idle, 01 = $5, 10 = $10.
//   Synchronises and debounces each sensor, then detects coin edges. Queues accepted
//   coins in a small FIFO and issues each as a single-cycle code followed by a 00 gap.
//   Rejects ambiguous, disabled or overflow coins.
// PARAMETERS
//   DEBOUNCE_CYCLES  4  consecutive stable synchronised samples needed to change debounced level
//   FIFO_DEPTH       4  queued coins; power of 2, >= 2
//   GAP_CYCLES       1  idle (00) cycles forced after every issued code; >= 1
// PORTS
//   clk          in   1                      system clock, rising edge
//   reset        in   1                      asynchronous, active-low; clears all state
//   coin5_raw    in   1                      raw $5 sensor, asynchronous, may bounce
//   coin10_raw   in   1                      raw $10 sensor, asynchronous, may bounce
//   accept_en    in   1                      1 = coins accepted and issued; 0 = new coins rejected
//   in_code      out  2                      registered coin code to vending FSM (00/01/10; 11 never)
//   coin_reject  out  1                      one-cycle pulse: coin returned to customer
//   fifo_count   out  $clog2(FIFO_DEPTH)+1   coins currently queued
// BEHAVIOUR
//   Reset (async assert, sync release): in_code=00, coin_reject=0, fifo_count=0,
//     synchronisers/debounced levels=0, counters=0, FSM=IDLE; queued coins discarded.
//     Reset during ISSUE drops in_code to 00 immediately.
//   Input path, per line:
//     2-flop synchroniser.
//     Debounce counter resets whenever the synchronised value equals the debounced level.
//     Otherwise the counter increments; on reaching DEBOUNCE_CYCLES the debounced level
//       flips and the counter clears.
//     Coin event = rising edge of debounced level (1-cycle). Falling edges are ignored.
//   Event resolution (same cycle as event, evaluated on pre-update fifo_count):
//     - both events in same cycle            -> coin_reject=1 next cycle, nothing queued
//     - accept_en=0                          -> reject
//     - fifo_count==FIFO_DEPTH (full)        -> reject, even if a pop occurs that cycle
//     - otherwise push (0=$5, 1=$10); coin_reject stays 0
//   Issue FSM:
//     IDLE: if fifo_count>0 and accept_en=1 -> pop head, go ISSUE.
//     ISSUE: in_code = 01 ($5) or 10 ($10) for exactly one cycle -> GAP.
//       Completes even if accept_en falls.
//     GAP: in_code=00 for GAP_CYCLES cycles -> IDLE.
//   Timing:
//     Push in the cycle after the event; earliest in_code assertion the cycle after push.
//     Simultaneous push and pop (non-full) leaves fifo_count unchanged.
//     FIFO pointers wrap modulo FIFO_DEPTH. Order is strictly FIFO.
//   Throughput: one code per 1+GAP_CYCLES cycles max. accept_en=0 holds queued coins, never drops them.
// TESTING
//   Clean $5 level held 20 cycles, D=4 -> exactly one in_code=01 pulse, then 00; fifo_count back to 0.
//   $10 line toggling every 2 cycles for 10 cycles, then stable high -> one in_code=10 only.
//   Both sensors rise same cycle -> one coin_reject pulse, in_code stays 00, fifo_count 0.
//   accept_en=0, five $5 coins with FIFO_DEPTH=4 -> all 5 rejected, count 0.
//   accept_en=1, issue blocked by queue backlog, 5 coins sent -> 4 queued, 5th rejected.
//   Queue $5,$10,$5 then enable -> in_code 01,00,10,00,01 (GAP=1), order preserved.
//   Assert reset mid-ISSUE with 3 queued -> in_code=00 same cycle, fifo_count=0;
//     no codes after release.

Source files
------------

// File: rtl/coin_acceptor_if.sv
// Coin acceptor bus: raw sensor lines and enable in, coin code/reject/occupancy out.
interface coin_acceptor_if #(
  parameter int FIFO_DEPTH = 4
);
  logic                          coin5_raw;
  logic                          coin10_raw;
  logic                          accept_en;
  logic [1:0]                    in_code;
  logic                          coin_reject;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;

  modport master (
    output coin5_raw, coin10_raw, accept_en,
    input  in_code, coin_reject, fifo_count
  );

  modport slave (
    input  coin5_raw, coin10_raw, accept_en,
    output in_code, coin_reject, fifo_count
  );
endinterface

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: synchronise and debounce the $5/$10 sensors, detect
// coin edges, queue accepted coins and issue each as a one-cycle code plus gap.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | in_code=00, waiting for a queued coin while accept_en=1
// S_ISSUE | in_code carries the popped coin for exactly one cycle
// S_GAP   | in_code=00 for GAP_CYCLES cycles; may pop the next coin on its last cycle
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int GAP_CYCLES      = 1
) (
  input  logic           clk,
  input  logic           reset,
  coin_acceptor_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  // Reset is asserted asynchronously but released in step with clk.
  logic rst_meta_q, rst_sync_q;
  logic rst_n;

  // Two-flop release synchroniser for the external reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  assign rst_n = rst_sync_q;

  // Index 0 is the $5 line, index 1 the $10 line.
  logic [1:0]      raw;
  logic [1:0]      meta_q, sync_q;
  logic [1:0]      deb_q, deb_d, deb_dly_q;
  logic [DB_W-1:0] db_cnt_q [2];
  logic [DB_W-1:0] db_cnt_d [2];
  logic [1:0]      ev;

  assign raw = {bus.coin10_raw, bus.coin5_raw};

  // Debounce: count consecutive samples that disagree with the debounced level.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      if (sync_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          deb_d[i] = ~deb_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Sensor synchronisers, debounced levels and their one-cycle-delayed copies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q    <= '0;
      sync_q    <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
    end else begin
      meta_q    <= raw;
      sync_q    <= meta_q;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  // Only rising debounced edges are coins; release of a sensor is ignored.
  assign ev = deb_q & ~deb_dly_q;

  logic                  full, push, pop, reject_d, reject_q;
  logic [CNT_W-1:0]      fifo_count_q;
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [FIFO_DEPTH-1:0] fifo_mem_q;

  // Full is judged before any pop this cycle, so a coin at full is returned.
  assign full     = (fifo_count_q == CNT_W'(FIFO_DEPTH));
  assign push     = (ev[0] ^ ev[1]) & bus.accept_en & ~full;
  assign reject_d = (ev[0] | ev[1]) & ~push;

  state_t          state_q, state_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [1:0]      in_code_q, in_code_d;
  logic            can_pop;
  logic [1:0]      head_code;

  assign can_pop   = (fifo_count_q != '0) & bus.accept_en;
  assign head_code = fifo_mem_q[rd_ptr_q] ? 2'b10 : 2'b01;

  // Issue FSM next state; a coin may be popped straight out of the last gap cycle.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    in_code_d = 2'b00;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (can_pop) begin
          pop       = 1'b1;
          in_code_d = head_code;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        gap_cnt_d = GAP_W'(GAP_CYCLES - 1);
        state_d   = S_GAP;
      end
      S_GAP: begin
        if (gap_cnt_q != '0) begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end else if (can_pop) begin
          pop       = 1'b1;
          in_code_d = head_code;
          state_d   = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state, gap down-counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      gap_cnt_q <= '0;
      in_code_q <= 2'b00;
      reject_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      in_code_q <= in_code_d;
      reject_q  <= reject_d;
    end
  end

  // Coin queue: one bit per entry (0 = $5, 1 = $10), pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_mem_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      if (push) begin
        fifo_mem_q[wr_ptr_q] <= ev[1];
        wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count_q <= fifo_count_q + CNT_W'(1);
        2'b01:   fifo_count_q <= fifo_count_q - CNT_W'(1);
        default: fifo_count_q <= fifo_count_q;
      endcase
    end
  end

  assign bus.in_code     = in_code_q;
  assign bus.coin_reject = reject_q;
  assign bus.fifo_count  = fifo_count_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: debounce, reject rules, queue order, gap timing, reset.
module tb_coin_acceptor;

  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  int   rej_cnt = 0;
  logic [1:0] prev_code = 2'b00;
  logic [1:0] code_log[$];

  coin_acceptor_if bus ();

  coin_acceptor dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] log_at(input int idx);
    if (idx < code_log.size()) return {30'd0, code_log[idx]};
    return 32'hFFFF_FFFF;
  endfunction

  // Log every issued code and reject pulse; a code must always be followed by 00.
  always @(negedge clk) begin
    if (prev_code != 2'b00) chk("code_then_gap", {30'd0, bus.in_code}, 32'd0);
    if (bus.in_code != 2'b00) code_log.push_back(bus.in_code);
    if (bus.coin_reject === 1'b1) rej_cnt++;
    prev_code = bus.in_code;
  end

  // $5 event lands one cycle before the $10 event; accept_en is open only for those two cycles.
  task automatic pair_round();
    @(negedge clk); bus.coin5_raw = 1'b1;
    @(negedge clk); bus.coin10_raw = 1'b1;
    repeat (5) @(negedge clk);
    bus.accept_en = 1'b1;
    repeat (2) @(negedge clk);
    bus.accept_en = 1'b0;
    repeat (4) @(negedge clk);
    bus.coin5_raw  = 1'b0;
    bus.coin10_raw = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int base;
  int r0;
  bit found;
  logic [1:0] exp_round[4];

  initial begin
    reset          = 1'b0;
    bus.coin5_raw  = 1'b0;
    bus.coin10_raw = 1'b0;
    bus.accept_en  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_code", {30'd0, bus.in_code}, 32'd0);
    chk("rst_reject", {31'd0, bus.coin_reject}, 32'd0);
    chk("rst_count", {29'd0, bus.fifo_count}, 32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Clean $5 level for 20 cycles.
    bus.accept_en = 1'b1;
    base = code_log.size(); r0 = rej_cnt;
    bus.coin5_raw = 1'b1;
    repeat (20) @(negedge clk);
    bus.coin5_raw = 1'b0;
    repeat (12) @(negedge clk);
    chk("clean5_ncodes", code_log.size() - base, 32'd1);
    chk("clean5_code", log_at(base), 32'd1);
    chk("clean5_count", {29'd0, bus.fifo_count}, 32'd0);
    chk("clean5_rej", rej_cnt - r0, 32'd0);

    // Bouncing $10 line (2-cycle pulses), then stable high.
    base = code_log.size(); r0 = rej_cnt;
    for (int i = 0; i < 5; i++) begin
      bus.coin10_raw = 1'b1; repeat (2) @(negedge clk);
      bus.coin10_raw = 1'b0; repeat (2) @(negedge clk);
    end
    bus.coin10_raw = 1'b1;
    repeat (20) @(negedge clk);
    bus.coin10_raw = 1'b0;
    repeat (12) @(negedge clk);
    chk("bounce10_ncodes", code_log.size() - base, 32'd1);
    chk("bounce10_code", log_at(base), 32'd2);
    chk("bounce10_rej", rej_cnt - r0, 32'd0);

    // Both sensors rise together.
    base = code_log.size(); r0 = rej_cnt;
    bus.coin5_raw = 1'b1; bus.coin10_raw = 1'b1;
    repeat (20) @(negedge clk);
    chk("both_rej", rej_cnt - r0, 32'd1);
    chk("both_ncodes", code_log.size() - base, 32'd0);
    chk("both_count", {29'd0, bus.fifo_count}, 32'd0);
    bus.coin5_raw = 1'b0; bus.coin10_raw = 1'b0;
    repeat (12) @(negedge clk);

    // Disabled: five $5 coins all returned.
    bus.accept_en = 1'b0;
    base = code_log.size(); r0 = rej_cnt;
    for (int i = 0; i < 5; i++) begin
      bus.coin5_raw = 1'b1; repeat (10) @(negedge clk);
      bus.coin5_raw = 1'b0; repeat (10) @(negedge clk);
    end
    chk("disabled_rej", rej_cnt - r0, 32'd5);
    chk("disabled_ncodes", code_log.size() - base, 32'd0);
    chk("disabled_count", {29'd0, bus.fifo_count}, 32'd0);

    // Four rounds build a backlog of four: issued 01,10,01,10; queue $5,$10,$5,$10.
    base = code_log.size(); r0 = rej_cnt;
    for (int i = 0; i < 4; i++) pair_round();
    exp_round[0] = 2'b01; exp_round[1] = 2'b10; exp_round[2] = 2'b01; exp_round[3] = 2'b10;
    chk("fill_count", {29'd0, bus.fifo_count}, 32'd4);
    chk("fill_rej", rej_cnt - r0, 32'd0);
    chk("fill_ncodes", code_log.size() - base, 32'd4);
    for (int i = 0; i < 4; i++) chk("fill_code", log_at(base + i), {30'd0, exp_round[i]});

    // Coin at full with a pop in the same cycle: rejected, head $5 issued.
    base = code_log.size(); r0 = rej_cnt;
    @(negedge clk); bus.coin5_raw = 1'b1;
    repeat (6) @(negedge clk);
    bus.accept_en = 1'b1;
    @(negedge clk);
    bus.accept_en = 1'b0;
    repeat (4) @(negedge clk);
    bus.coin5_raw = 1'b0;
    repeat (12) @(negedge clk);
    chk("full_rej", rej_cnt - r0, 32'd1);
    chk("full_count", {29'd0, bus.fifo_count}, 32'd3);
    chk("full_pop_code", log_at(base), 32'd1);

    // Drain $10,$5,$10 back-to-back: 10,00,01,00,10,00,00.
    bus.accept_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.in_code != 2'b00) found = 1'b1;
    end
    chk("drain_seen", {31'd0, found}, 32'd1);
    chk("drain_c0", {30'd0, bus.in_code}, 32'd2);
    @(negedge clk); chk("drain_c1", {30'd0, bus.in_code}, 32'd0);
    @(negedge clk); chk("drain_c2", {30'd0, bus.in_code}, 32'd1);
    @(negedge clk); chk("drain_c3", {30'd0, bus.in_code}, 32'd0);
    @(negedge clk); chk("drain_c4", {30'd0, bus.in_code}, 32'd2);
    @(negedge clk); chk("drain_c5", {30'd0, bus.in_code}, 32'd0);
    @(negedge clk); chk("drain_c6", {30'd0, bus.in_code}, 32'd0);
    chk("drain_count", {29'd0, bus.fifo_count}, 32'd0);
    bus.accept_en = 1'b0;
    repeat (5) @(negedge clk);

    // Three queued, then reset while the first is being issued.
    for (int i = 0; i < 3; i++) pair_round();
    chk("q3_count", {29'd0, bus.fifo_count}, 32'd3);
    bus.accept_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.in_code != 2'b00) found = 1'b1;
    end
    chk("issue_seen", {31'd0, found}, 32'd1);
    reset = 1'b0;
    #1;
    chk("rstmid_in_code", {30'd0, bus.in_code}, 32'd0);
    chk("rstmid_count", {29'd0, bus.fifo_count}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    base = code_log.size();
    repeat (20) @(negedge clk);
    chk("post_rst_ncodes", code_log.size() - base, 32'd0);
    chk("post_rst_count", {29'd0, bus.fifo_count}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
